bat_register_bank: RTL and testbench
====================================

Name: bat_register_bank

Overview:
- General-purpose register bank that responds to the per-register REGS_INC/REGS_RW/REGS_EN control vectors issued by the microsequencer each cycle.
- Holds eight 8-bit registers in this order: A, B, 3, 4, 5, 6, 7, OUT (index 0..7).
- Drives or samples the shared data bus, exposes A and B to the ALU, and flags bus contention.
- Every value committed to the OUT register is queued in a small FIFO and drained to an external sink over a valid/ready handshake.

Parameters:
- WIDTH, 8, data width of each register and of the bus.
- NREGS, 8, number of registers; index NREGS-1 is the OUT register.
- OUT_DEPTH, 4, depth of the OUT FIFO; must be a power of two, ≥2.

Ports:
- CLK  in  1  system clock; all state changes on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- REGS_INC  in  NREGS  per-register increment request.
- REGS_RW  in  NREGS  per-register direction: 1 = read out to bus, 0 = write from bus.
- REGS_EN  in  NREGS  per-register bus enable.
- BUS_IN  in  WIDTH  current value of the shared data bus.
- BUS_OUT  out  WIDTH  value this block drives onto the bus.
- BUS_DRIVE  out  1  1 when BUS_OUT is valid and must be placed on the bus.
- REG_A  out  WIDTH  current contents of register 0, to the ALU.
- REG_B  out  WIDTH  current contents of register 1, to the ALU.
- OUT_DATA  out  WIDTH  head entry of the OUT FIFO.
- OUT_VALID  out  1  1 when the OUT FIFO is non-empty.
- OUT_READY  in  1  sink accepts OUT_DATA this cycle.
- CLR_FLAGS  in  1  synchronous clear of the sticky flags.
- BUS_CONFLICT  out  1  sticky flag: multiple drivers, or load+increment on the same register.
- OUT_OVERFLOW  out  1  sticky flag: an OUT commit was dropped because the FIFO was full.

Behaviour:
- Reset (async, RST=1):
  - All registers clear to 0.
  - FIFO is emptied (pointers and count = 0).
  - BUS_OUT=0, BUS_DRIVE=0, OUT_VALID=0, BUS_CONFLICT=0, OUT_OVERFLOW=0.
  - Reset asserted mid-transfer discards all queued OUT entries; no pop is reported.
- Per-register decode for index i:
  - read_i = EN[i] & RW[i]
  - load_i = EN[i] & ~RW[i]
  - inc_i = INC[i] & ~EN[i]
- Read path (combinational, same cycle):
  - BUS_DRIVE = OR of all read_i.
  - BUS_OUT = the register with the lowest index among asserting read_i; 0 if none.
  - Reads never modify state.
- Load: when load_i is set, reg[i] <= BUS_IN at the rising edge.
- Increment:
  - When inc_i is set, reg[i] <= reg[i]+1 at the rising edge, modulo 2^WIDTH (0xFF -> 0x00).
  - No carry is output.
  - RW[i] is ignored for increment.
- INC[i] and load_i both set: the load wins, the increment is discarded, and BUS_CONFLICT sets.
- BUS_CONFLICT sets at the rising edge after any cycle with:
  - two or more read_i asserted, or
  - INC[i] & load_i for any i.
- REG_A and REG_B are direct register outputs with no added latency; a load in cycle N is visible in cycle N+1.
- OUT FIFO, first-word-fall-through:
  - Push: any cycle in which reg[NREGS-1] is loaded or incremented pushes the new value (post-update value).
  - Pop: OUT_VALID & OUT_READY.
  - An entry pushed into an empty FIFO appears on OUT_DATA/OUT_VALID one cycle after the committing edge; there is no same-cycle bypass.
  - Push when full with no pop in the same cycle: the entry is dropped, OUT_OVERFLOW sets, and reg[NREGS-1] still updates.
  - Push when full with a pop in the same cycle: both are accepted, count stays at OUT_DEPTH, and there is no overflow.
  - Pop when empty: impossible, because OUT_VALID=0.
  - Read/write pointers wrap modulo OUT_DEPTH.
  - Count width is log2(OUT_DEPTH)+1.
  - OUT_DATA holds its last value while empty (don't-care to the sink).
- CLR_FLAGS=1 clears both sticky flags at the edge.
  - If a new set condition occurs in the same cycle as CLR_FLAGS, the set wins.
- An all-zero control cycle (the sequencer's idle default) leaves all state unchanged.

Test Plan:
- Load then move:
  - Cycle 1: BUS_IN=0x5A with EN[3]=1, RW[3]=0.
  - Cycle 2: EN[3]=1, RW[3]=1.
  - Required: BUS_DRIVE=1 and BUS_OUT=0x5A in cycle 2; BUS_CONFLICT stays 0.
- Increment wrap:
  - Load reg 2 = 0xFF, then one cycle of INC[2]=1, RW[2]=0, EN=0.
  - Required: reg 2 reads back 0x00; no other register changes.
- Contention:
  - Cycle 1: EN[0]=EN[4]=1, RW[0]=RW[4]=1, with A=0x11 and reg4=0x44.
  - Required: BUS_OUT=0x11 that cycle and BUS_CONFLICT=1 next cycle.
  - Then CLR_FLAGS=1 for one cycle; required: BUS_CONFLICT=0.
- OUT FIFO fill/overflow:
  - OUT_READY=0; load OUT with 0x01..0x05 on consecutive cycles.
  - Required: OUT_VALID=1 with OUT_DATA=0x01; OUT_OVERFLOW=1 after the 5th commit.
  - Then OUT_READY=1; required: the sink receives exactly 0x01, 0x02, 0x03, 0x04, then OUT_VALID=0.
- Full push+pop:
  - Fill the FIFO with 4 entries, then in one cycle load OUT=0x99 with OUT_READY=1.
  - Required: no overflow; the drained sequence ends with 0x99.
- Async reset mid-drain:
  - With 3 entries queued and A=0x7E, pulse RST between clock edges.
  - Required: OUT_VALID, REG_A and both flags go to 0 immediately, without waiting for a CLK edge.

Source files
------------

// File: rtl/bat_register_bank_if.sv
// Bus/handshake bundle between the microsequencer side and bat_register_bank.
// Carries per-register control vectors, shared data bus, ALU taps, OUT drain stream and sticky flags.
// master = sequencer/test side (drives controls and bus), slave = register bank.
interface bat_register_bank_if #(
    parameter int WIDTH = 8,
    parameter int NREGS = 8
);
    logic [NREGS-1:0] REGS_INC;
    logic [NREGS-1:0] REGS_RW;
    logic [NREGS-1:0] REGS_EN;
    logic [WIDTH-1:0] BUS_IN;
    logic [WIDTH-1:0] BUS_OUT;
    logic             BUS_DRIVE;
    logic [WIDTH-1:0] REG_A;
    logic [WIDTH-1:0] REG_B;
    logic [WIDTH-1:0] OUT_DATA;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic             CLR_FLAGS;
    logic             BUS_CONFLICT;
    logic             OUT_OVERFLOW;

    modport master (
        output REGS_INC, REGS_RW, REGS_EN, BUS_IN, OUT_READY, CLR_FLAGS,
        input  BUS_OUT, BUS_DRIVE, REG_A, REG_B, OUT_DATA, OUT_VALID,
               BUS_CONFLICT, OUT_OVERFLOW
    );

    modport slave (
        input  REGS_INC, REGS_RW, REGS_EN, BUS_IN, OUT_READY, CLR_FLAGS,
        output BUS_OUT, BUS_DRIVE, REG_A, REG_B, OUT_DATA, OUT_VALID,
               BUS_CONFLICT, OUT_OVERFLOW
    );
endinterface

// File: rtl/bat_register_bank.sv
// Register bank of NREGS WIDTH-bit registers driven by per-register INC/RW/EN vectors; OUT commits are queued.
// Latency: bus read is combinational; loads/increments visible next cycle; OUT FIFO head appears one cycle after commit.
// Backpressure: OUT_READY low stalls the drain; a commit into a full, non-draining FIFO is dropped and flagged.
//
// Ports: CLK/RST (async active-high); bank (slave modport) carries REGS_INC/REGS_RW/REGS_EN, BUS_IN,
// BUS_OUT/BUS_DRIVE, REG_A/REG_B, OUT_DATA/OUT_VALID/OUT_READY, CLR_FLAGS, BUS_CONFLICT, OUT_OVERFLOW.

// Generic synchronous first-word-fall-through FIFO.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
// pop_dat holds the last popped word while empty.
module fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             empty,
    output logic             full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] last_dat;
    logic             wr_en;
    logic             rd_en;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign rd_en = pop & ~empty;
    // A full FIFO frees a slot in the same cycle it is popped, so push+pop on full is accepted.
    assign wr_en = push & (~full | rd_en);

    assign pop_dat = empty ? last_dat : mem[rd_ptr];

    // Storage needs no reset: entries are only observed after being written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            last_dat <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr   <= rd_ptr + PTR_W'(1);
                last_dat <= mem[rd_ptr];
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module bat_register_bank #(
    parameter int WIDTH     = 8,
    parameter int NREGS     = 8,
    parameter int OUT_DEPTH = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    bat_register_bank_if.slave   bank
);
    localparam int OUT_IDX = NREGS - 1;

    logic [WIDTH-1:0] regs [NREGS];

    logic [NREGS-1:0] read;
    logic [NREGS-1:0] load;
    logic [NREGS-1:0] inc;

    logic [WIDTH-1:0] bus_out;
    logic             multi_read;
    logic             conflict_set;

    logic             out_push;
    logic [WIDTH-1:0] out_push_dat;
    logic             out_pop;
    logic             out_empty;
    logic             out_full;
    logic             overflow_set;

    logic             conflict_q;
    logic             overflow_q;

    // Per-register decode. Increment only applies when the register is not on the bus,
    // so a register never sees both load and increment in the same cycle.
    assign read = bank.REGS_EN & bank.REGS_RW;
    assign load = bank.REGS_EN & ~bank.REGS_RW;
    assign inc  = bank.REGS_INC & ~bank.REGS_EN;

    // Lowest-index reader wins: scan from the top so lower indices overwrite.
    always_comb begin
        bus_out = '0;
        for (int i = NREGS - 1; i >= 0; i--) begin
            if (read[i]) begin
                bus_out = regs[i];
            end
        end
    end

    // x & (x-1) clears the lowest set bit; anything left means two or more readers.
    assign multi_read   = |(read & (read - NREGS'(1)));
    assign conflict_set = multi_read | (|(bank.REGS_INC & load));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (load[i]) begin
                    regs[i] <= bank.BUS_IN;
                end else if (inc[i]) begin
                    regs[i] <= regs[i] + WIDTH'(1);
                end
            end
        end
    end

    // OUT register commits push the post-update value into the drain queue.
    assign out_push     = load[OUT_IDX] | inc[OUT_IDX];
    assign out_push_dat = load[OUT_IDX] ? bank.BUS_IN : (regs[OUT_IDX] + WIDTH'(1));
    assign out_pop      = ~out_empty & bank.OUT_READY;
    assign overflow_set = out_push & out_full & ~out_pop;

    fifo_sync #(
        .WIDTH (WIDTH),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk      (CLK),
        .rst      (RST),
        .push     (out_push),
        .push_dat (out_push_dat),
        .pop      (out_pop),
        .pop_dat  (bank.OUT_DATA),
        .empty    (out_empty),
        .full     (out_full)
    );

    // Sticky flags: a set condition in the same cycle as a clear takes priority.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            conflict_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (conflict_set) begin
                conflict_q <= 1'b1;
            end else if (bank.CLR_FLAGS) begin
                conflict_q <= 1'b0;
            end
            if (overflow_set) begin
                overflow_q <= 1'b1;
            end else if (bank.CLR_FLAGS) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign bank.BUS_OUT      = bus_out;
    assign bank.BUS_DRIVE    = |read;
    assign bank.REG_A        = regs[0];
    assign bank.REG_B        = regs[1];
    assign bank.OUT_VALID    = ~out_empty;
    assign bank.BUS_CONFLICT = conflict_q;
    assign bank.OUT_OVERFLOW = overflow_q;
endmodule

// File: tb/tb_bat_register_bank.sv
module tb_bat_register_bank;
    localparam int W = 8;
    localparam int N = 8;
    localparam int D = 4;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    bat_register_bank_if #(.WIDTH(W), .NREGS(N)) bank_if ();

    bat_register_bank #(.WIDTH(W), .NREGS(N), .OUT_DEPTH(D)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .bank (bank_if)
    );

    int checks   = 0;
    int failures = 0;

    // Behavioural model: register file as an array, OUT FIFO as a queue.
    logic [7:0] m_regs [N];
    logic [7:0] m_q [$];
    bit         m_conf;
    bit         m_ovf;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0b expected=%0b", name, $time, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%02h expected=%02h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_regs[i] = 8'h00;
        m_q.delete();
        m_conf = 1'b0;
        m_ovf  = 1'b0;
    endtask

    // Compare every observable output against the model for the current inputs.
    task automatic model_compare();
        bit         drv;
        logic [7:0] bo;
        drv = 1'b0;
        bo  = 8'h00;
        for (int i = 0; i < N; i++) begin
            if (bank_if.REGS_EN[i] && bank_if.REGS_RW[i] && !drv) begin
                drv = 1'b1;
                bo  = m_regs[i];
            end
        end
        chk1("bus_drive", bank_if.BUS_DRIVE, drv);
        chk8("bus_out", bank_if.BUS_OUT, bo);
        chk8("reg_a", bank_if.REG_A, m_regs[0]);
        chk8("reg_b", bank_if.REG_B, m_regs[1]);
        chk1("out_valid", bank_if.OUT_VALID, m_q.size() != 0);
        if (m_q.size() != 0) chk8("out_data", bank_if.OUT_DATA, m_q[0]);
        chk1("bus_conflict", bank_if.BUS_CONFLICT, m_conf);
        chk1("out_overflow", bank_if.OUT_OVERFLOW, m_ovf);
    endtask

    // Apply what the coming rising edge must do.
    task automatic model_update();
        int   nread;
        bit   conf;
        bit   push;
        bit   pop;
        bit   was_full;
        bit   ovf_set;
        nread   = 0;
        conf    = 1'b0;
        push    = 1'b0;
        ovf_set = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (bank_if.REGS_EN[i] && bank_if.REGS_RW[i]) nread++;
            if (bank_if.REGS_INC[i] && bank_if.REGS_EN[i] && !bank_if.REGS_RW[i]) conf = 1'b1;
        end
        if (nread >= 2) conf = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (bank_if.REGS_EN[i] && !bank_if.REGS_RW[i]) begin
                m_regs[i] = bank_if.BUS_IN;
                if (i == N - 1) push = 1'b1;
            end else if (bank_if.REGS_INC[i] && !bank_if.REGS_EN[i]) begin
                m_regs[i] = m_regs[i] + 8'd1;
                if (i == N - 1) push = 1'b1;
            end
        end
        was_full = (m_q.size() == D);
        pop      = (m_q.size() != 0) && bank_if.OUT_READY;
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (!was_full || pop) m_q.push_back(m_regs[N-1]);
            else ovf_set = 1'b1;
        end
        if (bank_if.CLR_FLAGS) begin
            m_conf = 1'b0;
            m_ovf  = 1'b0;
        end
        if (conf) m_conf = 1'b1;
        if (ovf_set) m_ovf = 1'b1;
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic apply(input logic [7:0] inc, input logic [7:0] rw, input logic [7:0] en,
                         input logic [7:0] bus, input logic rdy, input logic clr);
        bank_if.REGS_INC  = inc;
        bank_if.REGS_RW   = rw;
        bank_if.REGS_EN   = en;
        bank_if.BUS_IN    = bus;
        bank_if.OUT_READY = rdy;
        bank_if.CLR_FLAGS = clr;
        #1;
        model_compare();
    endtask

    task automatic advance();
        model_update();
        @(negedge CLK);
    endtask

    task automatic idle(input logic rdy);
        apply(8'h00, 8'h00, 8'h00, 8'h00, rdy, 1'b0);
        advance();
    endtask

    initial begin
        logic [7:0] seq1 [4];
        logic [7:0] seq2 [4];
        logic [7:0] r_inc, r_rw, r_en, r_bus;
        logic       r_rdy, r_clr;
        seq1 = '{8'h01, 8'h02, 8'h03, 8'h04};
        seq2 = '{8'h22, 8'h23, 8'h24, 8'h99};

        RST = 1'b1;
        bank_if.REGS_INC  = '0;
        bank_if.REGS_RW   = '0;
        bank_if.REGS_EN   = '0;
        bank_if.BUS_IN    = '0;
        bank_if.OUT_READY = 1'b0;
        bank_if.CLR_FLAGS = 1'b0;
        model_reset();
        @(negedge CLK);
        #1;
        chk1("rst_bus_drive", bank_if.BUS_DRIVE, 1'b0);
        chk8("rst_bus_out", bank_if.BUS_OUT, 8'h00);
        chk8("rst_reg_a", bank_if.REG_A, 8'h00);
        chk1("rst_out_valid", bank_if.OUT_VALID, 1'b0);
        chk1("rst_conflict", bank_if.BUS_CONFLICT, 1'b0);
        chk1("rst_overflow", bank_if.OUT_OVERFLOW, 1'b0);
        @(negedge CLK);
        RST = 1'b0;

        // Load then move
        apply(8'h00, 8'h00, 8'h08, 8'h5A, 1'b0, 1'b0); advance();
        apply(8'h00, 8'h08, 8'h08, 8'h00, 1'b0, 1'b0);
        chk1("move_drive", bank_if.BUS_DRIVE, 1'b1);
        chk8("move_out", bank_if.BUS_OUT, 8'h5A);
        advance();
        apply(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        chk1("move_no_conflict", bank_if.BUS_CONFLICT, 1'b0);
        advance();

        // Increment wrap
        apply(8'h00, 8'h00, 8'h04, 8'hFF, 1'b0, 1'b0); advance();
        apply(8'h04, 8'h00, 8'h00, 8'h3C, 1'b0, 1'b0); advance();
        apply(8'h00, 8'h04, 8'h04, 8'h00, 1'b0, 1'b0);
        chk8("wrap_reg2", bank_if.BUS_OUT, 8'h00);
        advance();
        apply(8'h00, 8'h08, 8'h08, 8'h00, 1'b0, 1'b0);
        chk8("wrap_reg3_kept", bank_if.BUS_OUT, 8'h5A);
        advance();

        // Contention
        apply(8'h00, 8'h00, 8'h01, 8'h11, 1'b0, 1'b0); advance();
        apply(8'h00, 8'h00, 8'h10, 8'h44, 1'b0, 1'b0); advance();
        apply(8'h00, 8'h11, 8'h11, 8'h00, 1'b0, 1'b0);
        chk8("cont_bus_out", bank_if.BUS_OUT, 8'h11);
        advance();
        apply(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        chk1("cont_flag", bank_if.BUS_CONFLICT, 1'b1);
        chk8("cont_reg_a", bank_if.REG_A, 8'h11);
        advance();
        apply(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1); advance();
        apply(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        chk1("cont_cleared", bank_if.BUS_CONFLICT, 1'b0);
        advance();

        // OUT FIFO fill / overflow
        for (int k = 1; k <= 5; k++) begin
            apply(8'h00, 8'h00, 8'h80, 8'(k), 1'b0, 1'b0);
            advance();
        end
        apply(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        chk1("fill_valid", bank_if.OUT_VALID, 1'b1);
        chk8("fill_head", bank_if.OUT_DATA, 8'h01);
        chk1("fill_overflow", bank_if.OUT_OVERFLOW, 1'b1);
        advance();
        for (int k = 0; k < 4; k++) begin
            apply(8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
            chk1("drain1_valid", bank_if.OUT_VALID, 1'b1);
            chk8("drain1_data", bank_if.OUT_DATA, seq1[k]);
            advance();
        end
        apply(8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
        chk1("drain1_empty", bank_if.OUT_VALID, 1'b0);
        advance();
        apply(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1); advance();

        // Full push + pop in the same cycle
        for (int k = 0; k < 4; k++) begin
            apply(8'h00, 8'h00, 8'h80, 8'(8'h21 + k), 1'b0, 1'b0);
            advance();
        end
        apply(8'h00, 8'h00, 8'h80, 8'h99, 1'b1, 1'b0); advance();
        apply(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        chk1("fpp_no_overflow", bank_if.OUT_OVERFLOW, 1'b0);
        advance();
        for (int k = 0; k < 4; k++) begin
            apply(8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
            chk8("drain2_data", bank_if.OUT_DATA, seq2[k]);
            advance();
        end
        apply(8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
        chk1("drain2_empty", bank_if.OUT_VALID, 1'b0);
        advance();

        // Async reset mid-drain
        for (int k = 0; k < 3; k++) begin
            apply(8'h00, 8'h00, 8'h80, 8'(8'h31 + k), 1'b0, 1'b0);
            advance();
        end
        apply(8'h00, 8'h00, 8'h01, 8'h7E, 1'b0, 1'b0); advance();
        apply(8'h00, 8'h03, 8'h03, 8'h00, 1'b0, 1'b0); advance();
        apply(8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        chk1("pre_rst_valid", bank_if.OUT_VALID, 1'b1);
        chk8("pre_rst_reg_a", bank_if.REG_A, 8'h7E);
        chk1("pre_rst_conflict", bank_if.BUS_CONFLICT, 1'b1);
        RST = 1'b1;
        #1;
        chk1("arst_valid", bank_if.OUT_VALID, 1'b0);
        chk8("arst_reg_a", bank_if.REG_A, 8'h00);
        chk1("arst_conflict", bank_if.BUS_CONFLICT, 1'b0);
        chk1("arst_overflow", bank_if.OUT_OVERFLOW, 1'b0);
        RST = 1'b0;
        model_reset();
        advance();
        idle(1'b1);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            r_inc = 8'($urandom) & 8'($urandom) & 8'($urandom);
            r_en  = 8'($urandom) & 8'($urandom) & 8'($urandom);
            r_rw  = 8'($urandom);
            r_bus = 8'($urandom);
            if ($urandom_range(2) == 0) begin
                r_en[7] = 1'b1;
                r_rw[7] = 1'b0;
            end
            if ((c % 200) < 100) r_rdy = ($urandom_range(3) == 0);
            else                 r_rdy = ($urandom_range(3) != 0);
            r_clr = ($urandom_range(15) == 0);
            apply(r_inc, r_rw, r_en, r_bus, r_rdy, r_clr);
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
